// File: rtl/wbu_pkg.sv
// Shared definitions for the debug-bus return path.
// Header codes, newline character, serializer states, symbol count.
package wbu_pkg;

  localparam logic [5:0] HDR_IDLE      = 6'h00;
  localparam logic [5:0] HDR_IDLE_BUSY = 6'h01;
  localparam logic [5:0] HDR_INTERRUPT = 6'h04;

  localparam logic [6:0] CHR_NEWLINE = 7'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_NEWLINE
  } state_t;

  // Number of 6-bit symbols carried by a codeword, from its top 3 bits
  function automatic logic [2:0] sym_count(input logic [2:0] hdr);
    if (hdr[2])
      return 3'd6;
    else
      return {1'b0, hdr[1:0]} + 3'd1;
  endfunction

endpackage

// File: rtl/wbu_sixbit_to_ascii.sv
// Maps a 6-bit symbol onto its printable ASCII character.
// 0-9, A-Z, a-z, then '@' and '%'.
module wbu_sixbit_to_ascii (
  input  logic [5:0] sym,
  output logic [6:0] ch
);

  logic [6:0] s7;

  assign s7 = {1'b0, sym};

  always_comb begin
    ch = 7'h25;
    unique case (1'b1)
      (sym < 6'd10):
        ch = 7'h30 + s7;
      (sym >= 6'd10 && sym < 6'd36):
        ch = 7'h37 + s7;
      (sym >= 6'd36 && sym < 6'd62):
        ch = 7'h3D + s7;
      (sym == 6'd62):
        ch = 7'h40;
      (sym == 6'd63):
        ch = 7'h25;
    endcase
  end

endmodule

// File: rtl/wbu_deword_hex.sv
// Splits 36-bit debug-bus codewords into ASCII characters for the UART.
// Single-symbol words are followed by a newline.
module wbu_deword_hex
  import wbu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [35:0] i_codword,
  output logic        o_busy,
  output logic        o_stb,
  output logic [6:0]  o_char,
  input  logic        i_tx_busy
);

  state_t      state;
  logic [29:0] sreg;
  logic [2:0]  rem;
  logic        one_sym;
  logic [5:0]  sym;
  logic [6:0]  sym_char;
  logic        hs;

  // The first symbol comes straight off the input on accept
  assign sym = (state == ST_IDLE) ? i_codword[35:30]
                                  : sreg[29:24];
  assign hs  = o_stb && !i_tx_busy;

  wbu_sixbit_to_ascii u_map (
    .sym (sym),
    .ch  (sym_char)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      rem     <= '0;
      one_sym <= 1'b0;
      o_busy  <= 1'b0;
      o_stb   <= 1'b0;
      o_char  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_stb) begin
            sreg    <= i_codword[29:0];
            rem     <= sym_count(i_codword[35:33]) - 3'd1;
            one_sym <= (i_codword[35:33] == 3'b000);
            o_char  <= sym_char;
            o_stb   <= 1'b1;
            o_busy  <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (hs) begin
            if (rem != 3'd0) begin
              sreg   <= {sreg[23:0], 6'h00};
              rem    <= rem - 3'd1;
              o_char <= sym_char;
            end else if (one_sym) begin
              o_char <= CHR_NEWLINE;
              state  <= ST_NEWLINE;
            end else begin
              o_stb  <= 1'b0;
              o_busy <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
        ST_NEWLINE: begin
          if (hs) begin
            o_stb  <= 1'b0;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          o_stb  <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbu_deword_hex.sv
// Testbench for wbu_deword_hex.
// Expected characters queue up on drive and are popped on handshake.
module tb_wbu_deword_hex;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_stb;
  logic [35:0] cw;
  logic        o_busy;
  logic        o_stb;
  logic [6:0]  o_char;
  logic        i_tx_busy;

  int n_chk = 0;
  int n_err = 0;
  int n_hs  = 0;
  int h0;

  logic [6:0] exp_q[$];

  string amap =
    "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz@%";

  always #5 clk = ~clk;

  wbu_deword_hex dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_stb     (i_stb),
    .i_codword (cw),
    .o_busy    (o_busy),
    .o_stb     (o_stb),
    .o_char    (o_char),
    .i_tx_busy (i_tx_busy)
  );

  task automatic chk(input string tag, input logic [35:0] got,
                     input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model_char(input logic [5:0] s);
    byte b;
    b = amap[int'(s)];
    return b[6:0];
  endfunction

  task automatic push_word(input logic [35:0] w);
    int k;
    logic [5:0] s;
    case (w[35:33])
      3'b000:  k = 1;
      3'b001:  k = 2;
      3'b010:  k = 3;
      3'b011:  k = 4;
      default: k = 6;
    endcase
    for (int i = 0; i < k; i++) begin
      s = w[35-6*i -: 6];
      exp_q.push_back(model_char(s));
    end
    if (k == 1) exp_q.push_back(7'h0A);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!i_reset && o_stb) begin
      if (exp_q.size() == 0) begin
        chk("extra_char", 36'(exp_q.size()), 36'd1);
      end else begin
        chk("char", {29'h0, o_char}, {29'h0, exp_q[0]});
        if (!i_tx_busy) begin
          void'(exp_q.pop_front());
          n_hs++;
        end
      end
    end
  end

  task automatic short_word(input logic [35:0] w,
                            input logic [6:0] c);
    tick();
    i_stb = 1'b1;
    cw = w;
    push_word(w);
    h0 = n_hs;
    tick();
    i_stb = 1'b0;
    @(negedge clk);
    chk("short_c1_stb", o_stb, 1);
    chk("short_c1_char", o_char, c);
    tick();
    @(negedge clk);
    chk("short_c2_stb", o_stb, 1);
    chk("short_nl", o_char, 7'h0A);
    tick();
    @(negedge clk);
    chk("short_end_stb", o_stb, 0);
    chk("short_end_busy", o_busy, 0);
    chk("short_hs", 36'(n_hs - h0), 36'd2);
  endtask

  task automatic run_word(input logic [35:0] w, input bit rnd);
    tick();
    i_stb = 1'b1;
    cw = w;
    push_word(w);
    tick();
    i_stb = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_busy) break;
      tick();
      if (rnd) i_tx_busy = 1'($urandom_range(0, 1));
    end
    i_tx_busy = 1'b0;
    chk("drain_q", 36'(exp_q.size()), 36'd0);
    chk("drain_busy", o_busy, 0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_stb = 1'b1;
    cw = 36'hF_FFFF_FFFF;
    i_tx_busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_stb", o_stb, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_char", o_char, 0);
    tick();
    i_reset = 1'b0;
    i_stb = 1'b0;

    short_word(36'h0, 7'h30);
    short_word(36'h1_0000_0000, 7'h34);

    tick();
    i_stb = 1'b1;
    cw = 36'hF_FFFF_FFFF;
    push_word(cw);
    h0 = n_hs;
    tick();
    i_stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ff_stb", o_stb, 1);
      chk("ff_char", o_char, 7'h25);
      tick();
    end
    @(negedge clk);
    chk("ff_end_stb", o_stb, 0);
    chk("ff_hs", 36'(n_hs - h0), 36'd6);

    tick();
    i_stb = 1'b1;
    cw = {6'h0A, 6'h23, 24'h0};
    push_word(cw);
    h0 = n_hs;
    tick();
    i_stb = 1'b0;
    i_tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_stb", o_stb, 1);
      chk("stall_char", o_char, 7'h41);
      tick();
    end
    i_tx_busy = 1'b0;
    @(negedge clk);
    chk("stall_rel_char", o_char, 7'h41);
    tick();
    @(negedge clk);
    chk("stall_2nd_char", o_char, 7'h5A);
    tick();
    @(negedge clk);
    chk("stall_end_stb", o_stb, 0);
    chk("stall_hs", 36'(n_hs - h0), 36'd2);

    tick();
    i_stb = 1'b1;
    cw = {6'h0B, 6'h01, 24'h0};
    push_word(cw);
    push_word(36'h0);
    h0 = n_hs;
    tick();
    cw = 36'h0;
    @(negedge clk);
    chk("b2b_c1", o_stb, 1);
    tick();
    @(negedge clk);
    chk("b2b_c2", o_stb, 1);
    tick();
    @(negedge clk);
    chk("b2b_bubble_stb", o_stb, 0);
    chk("b2b_bubble_busy", o_busy, 0);
    tick();
    i_stb = 1'b0;
    @(negedge clk);
    chk("b2b_c3", o_stb, 1);
    chk("b2b_c3_char", o_char, 7'h30);
    tick();
    @(negedge clk);
    chk("b2b_c4", o_stb, 1);
    tick();
    @(negedge clk);
    chk("b2b_end", o_stb, 0);
    chk("b2b_hs", 36'(n_hs - h0), 36'd4);

    run_word({6'h1A, 6'h24, 6'h3E, 6'h09, 12'h0}, 1'b0);
    run_word({6'h10, 6'h3D, 6'h0A, 18'h0}, 1'b0);
    for (int i = 0; i < 6; i++)
      run_word({4'($urandom), 32'($urandom)}, 1'b1);

    tick();
    i_stb = 1'b1;
    cw = {6'h20, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
    push_word(cw);
    tick();
    i_stb = 1'b0;
    tick();
    tick();
    i_tx_busy = 1'b1;
    @(negedge clk);
    chk("mid_stall_char", o_char, 7'h32);
    tick();
    i_reset = 1'b1;
    i_stb = 1'b1;
    cw = 36'h0;
    exp_q.delete();
    tick();
    i_reset = 1'b0;
    i_stb = 1'b0;
    i_tx_busy = 1'b0;
    @(negedge clk);
    chk("mid_rst_stb", o_stb, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_char", o_char, 0);
    short_word(36'h0, 7'h30);

    chk("final_q", 36'(exp_q.size()), 36'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
